// File: rtl/icache_fill_ctrl_pkg.sv
// Shared instruction-cache definitions: fill FSM encodings, default geometry, address fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icache_fill_ctrl_pkg;

    // Default geometry: 64 lines of 8 x 16-bit words; the tag takes the remaining bits.
    localparam int DEF_INDEX_BITS  = 6;
    localparam int DEF_OFFSET_BITS = 3;
    localparam int WORDS_PER_LINE  = 1 << DEF_OFFSET_BITS;

    // Byte-address field positions for the default geometry (bit 0 is the byte select).
    localparam int TAG_MSB   = 15;
    localparam int TAG_LSB   = 10;
    localparam int INDEX_MSB = 9;
    localparam int INDEX_LSB = 4;
    localparam int WORD_MSB  = 3;
    localparam int WORD_LSB  = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        FILL_REQ  = 2'b01,
        FILL_WAIT = 2'b10,
        DONE      = 2'b11
    } fill_state_t;

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Latency: n/a (wiring only).
// Backpressure: cpu_stall holds the fetch side; memory returns are never throttled.
// Optional ICACHE_PERF_CNT_EN adds the hit/miss counters to the bundle.
interface icache_fill_ctrl_if;
    logic [15:0] cpu_addr;
    logic        cpu_req;
    logic [15:0] cpu_instr;
    logic        cpu_stall;
    logic        inv_all;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
`ifdef ICACHE_PERF_CNT_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    // Environment side: drives the fetch request and the memory returns.
    modport master (
        output cpu_addr, cpu_req, inv_all, mem_rdata, mem_rvalid,
        input  cpu_instr, cpu_stall, mem_req, mem_addr, hit_cnt, miss_cnt
    );
    // Cache side.
    modport slave (
        input  cpu_addr, cpu_req, inv_all, mem_rdata, mem_rvalid,
        output cpu_instr, cpu_stall, mem_req, mem_addr, hit_cnt, miss_cnt
    );
`else
    // Environment side: drives the fetch request and the memory returns.
    modport master (
        output cpu_addr, cpu_req, inv_all, mem_rdata, mem_rvalid,
        input  cpu_instr, cpu_stall, mem_req, mem_addr
    );
    // Cache side.
    modport slave (
        input  cpu_addr, cpu_req, inv_all, mem_rdata, mem_rvalid,
        output cpu_instr, cpu_stall, mem_req, mem_addr
    );
`endif
endinterface

// File: rtl/icache_fill_ctrl_data_array.sv
// Instruction-cache data store: one word per (line, word) slot, 512 x 16 by default.
// Latency: read is combinational, write lands at the next rising edge.
// Backpressure: none; a write is accepted every cycle we is high.
module icache_data_array
    import icache_fill_ctrl_pkg::*;
#(
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [OFFSET_BITS-1:0] wr_word,
    input  logic [15:0]            wr_data,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_word,
    output logic [15:0]            rd_data
);
    localparam int DEPTH = 1 << (INDEX_BITS + OFFSET_BITS);

    logic [15:0] mem [DEPTH];

    // Fill write port; contents are deliberately not reset, the valid bits guard them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_index, rd_word}];

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped I-cache: same-cycle hits, 8-word line fill on a miss. Optional macro ICACHE_PERF_CNT_EN.
// Latency: hit 0 cycles; miss stalls 9+L cycles for memory latency L, word delivered in DONE.
// Backpressure: cpu_stall holds the PC during a fill; memory returns are taken unconditionally.
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    icache_fill_ctrl_if.slave bus
);
    localparam int TAG_BITS  = 16 - INDEX_BITS - OFFSET_BITS - 1;
    localparam int LINE_BITS = TAG_BITS + INDEX_BITS;
    localparam int LINES     = 1 << INDEX_BITS;

    fill_state_t            state;
    logic [LINES-1:0]       valid;
    logic [TAG_BITS-1:0]    tag_arr [LINES];
    logic [LINE_BITS-1:0]   miss_line;
    logic [OFFSET_BITS-1:0] req_cnt;
    logic [OFFSET_BITS-1:0] rsp_cnt;
    logic                   pend_inv;

    logic [TAG_BITS-1:0]    cpu_tag;
    logic [INDEX_BITS-1:0]  cpu_index;
    logic [OFFSET_BITS-1:0] cpu_word;
    logic [TAG_BITS-1:0]    miss_tag;
    logic [INDEX_BITS-1:0]  miss_index;
    logic                   unused_addr_lsb;

    logic                   in_idle;
    logic                   filling;
    logic                   hit;
    logic                   miss;
    logic                   last_rsp;
    logic                   data_we;
    logic [INDEX_BITS-1:0]  rd_index;
    logic [15:0]            rd_data;

    assign cpu_tag         = bus.cpu_addr[15 -: TAG_BITS];
    assign cpu_index       = bus.cpu_addr[OFFSET_BITS+1 +: INDEX_BITS];
    assign cpu_word        = bus.cpu_addr[1 +: OFFSET_BITS];
    assign unused_addr_lsb = bus.cpu_addr[0];
    assign miss_tag        = miss_line[LINE_BITS-1 -: TAG_BITS];
    assign miss_index      = miss_line[INDEX_BITS-1:0];

    assign in_idle  = (state == IDLE);
    assign filling  = (state == FILL_REQ) || (state == FILL_WAIT);
    assign hit      = in_idle && bus.cpu_req && valid[cpu_index] && (tag_arr[cpu_index] == cpu_tag);
    assign miss     = in_idle && bus.cpu_req && !hit;
    assign last_rsp = filling && bus.mem_rvalid && (&rsp_cnt);
    assign data_we  = rst_n && filling && bus.mem_rvalid;

    // DONE is a forced hit into the freshly filled line, whatever index the PC now points at.
    assign rd_index = (state == DONE) ? miss_index : cpu_index;

    icache_data_array #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_data (
        .clk      (clk),
        .we       (data_we),
        .wr_index (miss_index),
        .wr_word  (rsp_cnt),
        .wr_data  (bus.mem_rdata),
        .rd_index (rd_index),
        .rd_word  (cpu_word),
        .rd_data  (rd_data)
    );

    // Outputs are forced quiet while reset is held so a mid-fill reset stops requests at once.
    assign bus.cpu_stall = rst_n && (filling || miss);
    assign bus.cpu_instr = (rst_n && (hit || state == DONE)) ? rd_data : 16'h0000;
    assign bus.mem_req   = rst_n && (state == FILL_REQ);
    assign bus.mem_addr  = {miss_line, req_cnt, 1'b0};

    // Tag array: written once per fill, on the eighth return; never reset.
    always_ff @(posedge clk) begin
        if (rst_n && last_rsp) begin
            tag_arr[miss_index] <= miss_tag;
        end
    end

    // Fill FSM with valid bits, counters and the pending-invalidate flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            req_cnt   <= '0;
            rsp_cnt   <= '0;
            pend_inv  <= 1'b0;
            miss_line <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.inv_all) begin
                        valid <= '0;
                    end
                    if (miss) begin
                        miss_line <= bus.cpu_addr[15 -: LINE_BITS];
                        req_cnt   <= '0;
                        rsp_cnt   <= '0;
                        state     <= FILL_REQ;
                    end
                end
                FILL_REQ, FILL_WAIT: begin
                    if (state == FILL_REQ) begin
                        req_cnt <= req_cnt + 1'b1;
                        if (&req_cnt) begin
                            state <= FILL_WAIT;
                        end
                    end
                    if (bus.mem_rvalid) begin
                        rsp_cnt <= rsp_cnt + 1'b1;
                    end
                    // With short latency the last return can land while still requesting.
                    if (last_rsp) begin
                        state <= DONE;
                        if (!pend_inv && !bus.inv_all) begin
                            valid[miss_index] <= 1'b1;
                        end
                    end
                    if (bus.inv_all) begin
                        valid    <= '0;
                        pend_inv <= 1'b1;
                    end
                end
                DONE: begin
                    pend_inv <= 1'b0;
                    if (bus.inv_all) begin
                        valid <= '0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    // Saturating hit/miss counters; DONE forced hits are not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && hit_cnt != 16'hFFFF) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (miss && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    assign bus.hit_cnt  = hit_cnt;
    assign bus.miss_cnt = miss_cnt;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: fetch-level cache model plus a latency-programmable memory.
// Latency: memory returns each request lat cycles after it is issued (lat=0 means same cycle).
// Backpressure: the fetch task holds cpu_req until cpu_stall drops.
module tb_icache_fill_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    icache_fill_ctrl_if bus ();

    icache_fill_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 4;
    int cyc      = 0;

    // Backing memory contents: every word is its own address XOR a constant.
    function automatic logic [15:0] memword(input logic [15:0] a);
        return (a & 16'hFFFE) ^ 16'hBEEF;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: queue of outstanding requests, returned in order after lat cycles.
    logic [15:0] q_addr[$];
    int          q_due[$];
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (bus.mem_req === 1'b1) begin
                q_addr.push_back(bus.mem_addr);
                q_due.push_back(cyc + lat);
            end
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = memword(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 16'hDEAD;
            end
        end
    end

    // Record of issued memory addresses for the literal fill-order check.
    logic [15:0] seen[$];
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) seen.push_back(bus.mem_addr);
    end

    // Fetch-level model: k counts cycles since the miss (-1 = no fill in progress).
    bit          mvalid [64];
    logic [5:0]  mtag   [64];
    int          k      = -1;
    logic [15:0] mline  = 16'h0000;
    bit          mpend  = 1'b0;
    int          m_hits = 0;
    int          m_miss = 0;

    always @(negedge clk) begin : model_cmp
        logic [15:0] e_instr;
        logic [15:0] e_maddr;
        logic        e_stall;
        logic        e_mreq;
        int          idx;
        logic [5:0]  tg;
        e_instr = 16'h0000;
        e_maddr = 16'h0000;
        e_stall = 1'b0;
        e_mreq  = 1'b0;
        idx     = int'(bus.cpu_addr[9:4]);
        tg      = bus.cpu_addr[15:10];
`ifdef ICACHE_PERF_CNT_EN
        check("cyc_hit_cnt", bus.hit_cnt, 16'(m_hits));
        check("cyc_miss_cnt", bus.miss_cnt, 16'(m_miss));
`endif
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
            k = -1; mpend = 1'b0; m_hits = 0; m_miss = 0;
        end else if (k < 0) begin
            if (bus.cpu_req) begin
                if (mvalid[idx] && mtag[idx] == tg) begin
                    e_instr = memword(bus.cpu_addr);
                    if (m_hits < 65535) m_hits++;
                end else begin
                    e_stall = 1'b1;
                    mline   = {bus.cpu_addr[15:4], 4'h0};
                    k       = 1;
                    mpend   = 1'b0;
                    if (m_miss < 65535) m_miss++;
                end
            end
            if (bus.inv_all) for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        end else if (k == 9 + lat) begin
            e_instr = memword({mline[15:4], bus.cpu_addr[3:0]});
            if (!mpend) begin
                mvalid[int'(mline[9:4])] = 1'b1;
                mtag[int'(mline[9:4])]   = mline[15:10];
            end
            if (bus.inv_all) for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
            k = -1;
            mpend = 1'b0;
        end else begin
            e_stall = 1'b1;
            if (k <= 8) begin
                e_mreq  = 1'b1;
                e_maddr = mline + 16'(2 * (k - 1));
            end
            if (bus.inv_all) begin
                for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
                mpend = 1'b1;
            end
            k++;
        end
        check("cyc_stall", 16'(bus.cpu_stall), 16'(e_stall));
        check("cyc_instr", bus.cpu_instr, e_instr);
        check("cyc_mem_req", 16'(bus.mem_req), 16'(e_mreq));
        if (e_mreq) check("cyc_mem_addr", bus.mem_addr, e_maddr);
    end

    // One fetch: hold the request until the stall drops; optional inv_all / reset at cycle offsets.
    task automatic fetch(input logic [15:0] a, input int inv_at, input int rst_at,
                         output int stalls, output logic [15:0] ins);
        bit done;
        done   = 1'b0;
        stalls = 0;
        ins    = 16'hxxxx;
        bus.cpu_addr = a;
        bus.cpu_req  = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            bus.inv_all = (i == inv_at);
            rst_n       = !(i == rst_at);
            @(negedge clk);
            if (i == rst_at) begin
                done = 1'b1;
            end else if (!bus.cpu_stall) begin
                ins  = bus.cpu_instr;
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        bus.cpu_req = 1'b0;
        bus.inv_all = 1'b0;
        rst_n       = 1'b1;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL fetch_timeout %h: stall never released in 64 cycles, required release", a);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          st;
        logic [15:0] ins;
        rst_n          = 1'b0;
        bus.cpu_addr   = 16'h0000;
        bus.cpu_req    = 1'b0;
        bus.inv_all    = 1'b0;
        idle(2);
        @(negedge clk);
        check("reset_stall", 16'(bus.cpu_stall), 16'h0000);
        check("reset_mem_req", 16'(bus.mem_req), 16'h0000);
        check("reset_instr", bus.cpu_instr, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Cold miss at L=4, then a hit in the same line.
        lat = 4;
        seen.delete();
        fetch(16'h0000, -1, -1, st, ins);
        check("cold_stall_cycles", 16'(st), 16'd13);
        check("cold_done_word", ins, 16'hBEEF);
        check("cold_req_count", 16'(seen.size()), 16'd8);
        for (int i = 0; i < 8 && i < seen.size(); i++) check("cold_req_addr", seen[i], 16'(2 * i));
        fetch(16'h000A, -1, -1, st, ins);
        check("hit_stall_cycles", 16'(st), 16'd0);
        check("hit_word", ins, 16'hBEE5);

        // Conflict on index 0: tag 1 evicts tag 0 and vice versa.
        fetch(16'h0400, -1, -1, st, ins);
        check("conflict_stall", 16'(st), 16'd13);
        check("conflict_word", ins, 16'hBAEF);
        fetch(16'h0000, -1, -1, st, ins);
        check("refetch_stall", 16'(st), 16'd13);

        // Same-cycle returns finish inside FILL_REQ; one-cycle returns need a FILL_WAIT cycle.
        lat = 0;
        fetch(16'h0210, -1, -1, st, ins);
        check("lat0_stall", 16'(st), 16'd9);
        check("lat0_word", ins, 16'hBCFF);
        lat = 1;
        fetch(16'h0300, -1, -1, st, ins);
        check("lat1_stall", 16'(st), 16'd10);
        fetch(16'h021E, -1, -1, st, ins);
        check("lat0_line_hit_stall", 16'(st), 16'd0);
        check("lat0_line_hit_word", ins, 16'hBCF1);

        // inv_all inside FILL_WAIT: word delivered, line left invalid.
        lat = 4;
        fetch(16'h0020, 10, -1, st, ins);
        check("inv_fill_stall", 16'(st), 16'd13);
        check("inv_fill_word", ins, 16'hBECF);
        fetch(16'h0020, -1, -1, st, ins);
        check("inv_fill_refetch_stall", 16'(st), 16'd13);
        fetch(16'h0400, -1, -1, st, ins);
        check("inv_other_line_stall", 16'(st), 16'd13);
        // inv_all in IDLE: same-cycle lookup still hits, the next one misses.
        fetch(16'h0020, 0, -1, st, ins);
        check("inv_idle_hit_stall", 16'(st), 16'd0);
        check("inv_idle_hit_word", ins, 16'hBECF);
        fetch(16'h0020, -1, -1, st, ins);
        check("inv_idle_after_stall", 16'(st), 16'd13);

        // Reset in the 5th fill cycle; stale returns drain while idle.
        fetch(16'h0100, -1, 5, st, ins);
        idle(8);
        check("rst_queue_drained", 16'(q_due.size()), 16'd0);
        fetch(16'h0000, -1, -1, st, ins);
        check("rst_cleared_valid", 16'(st), 16'd13);
        fetch(16'h0100, -1, -1, st, ins);
        check("rst_refill_stall", 16'(st), 16'd13);
        check("rst_refill_word", ins, 16'hBFEF);
        fetch(16'h0106, -1, -1, st, ins);
        check("rst_refill_hit", ins, 16'hBFE9);

`ifdef ICACHE_PERF_CNT_EN
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        fetch(16'h0100, -1, -1, st, ins);
        for (int i = 1; i < 8; i++) fetch(16'h0100 + 16'(2 * i), -1, -1, st, ins);
        check("perf_miss_cnt", bus.miss_cnt, 16'd1);
        check("perf_hit_cnt", bus.hit_cnt, 16'd7);
        bus.cpu_addr = 16'h0100;
        bus.cpu_req  = 1'b1;
        idle(70000);
        bus.cpu_req = 1'b0;
        check("perf_hit_sat", bus.hit_cnt, 16'hFFFF);
        check("perf_miss_hold", bus.miss_cnt, 16'd1);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time, required finish");
        $fatal(1, "watchdog");
    end

endmodule
